// File: rtl/clock_disp_ctrl.sv
// rtl/clock_disp_ctrl.sv - HH:MM:SS BCD clock with key-driven time setting and display control
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   key_mode  in   1   one-cycle pulse, steps RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN
//   key_up    in   1   one-cycle pulse, increments the field selected by the SET state
//   din       out  24  BCD digits {hh, mm, ss}, digit i = din[4i+3:4i]
//   din_mask  out  6   digit enable, high = shown (selected field blinks while setting)
//   point_n   out  6   decimal points, low = lit
//   mode      out  2   0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC

module clock_disp_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_up,
  output logic [23:0] din,
  output logic [5:0]  din_mask,
  output logic [5:0]  point_n,
  output logic [1:0]  mode
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FREQ / 2);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_SET_HR  = 2'd1;
  localparam logic [1:0] ST_SET_MIN = 2'd2;
  localparam logic [1:0] ST_SET_SEC = 2'd3;

  localparam logic [5:0] POINT_LIT = 6'b101011;
  localparam logic [5:0] POINT_OFF = 6'b111111;
  localparam logic [5:0] MASK_ALL  = 6'b111111;

  // BCD increment 00..59, wrapping to 00
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD increment 00..23, wrapping to 00
  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [7:0]    hr_q, hr_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;

  logic [23:0]   din_q, din_d;
  logic [5:0]    mask_q, mask_d;
  logic [5:0]    point_q, point_d;
  logic [1:0]    mode_q, mode_d;

  logic          tick;
  logic          up_ok;
  logic          enter_set;

  // State, prescaler and blink control
  always_comb begin
    tick      = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    // key_mode wins over key_up; key_up does nothing in RUN
    up_ok     = key_up && !key_mode && (state_q != ST_RUN);
    state_d   = key_mode ? state_q + 2'd1 : state_q;
    enter_set = key_mode && (state_d != ST_RUN);

    // Counting only while RUN both now and next; the cycle that returns to
    // RUN still loads 0 so the first tick lands a full CLK_FREQ later.
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end else begin
      presc_d = '0;
    end

    // Restart the blink phase so the field is visible right after any edit action
    if (enter_set || up_ok) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = !blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_on_d  = blink_on_q;
    end
  end

  // Time of day
  always_comb begin
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q;
    if (tick) begin
      sec_d = bcd_inc60(sec_q);
      if (sec_q == 8'h59) begin
        min_d = bcd_inc60(min_q);
        if (min_q == 8'h59) begin
          hr_d = bcd_inc24(hr_q);
        end
      end
    end else if (up_ok) begin
      case (state_q)
        ST_SET_HR:  hr_d  = bcd_inc24(hr_q);
        ST_SET_MIN: min_d = bcd_inc60(min_q);
        ST_SET_SEC: sec_d = bcd_inc60(sec_q);
        default:    ;
      endcase
    end
  end

  // Display outputs are built from next-state values so a tick or key_up
  // shows on din in the cycle right after the event.
  always_comb begin
    din_d  = {hr_d, min_d, sec_d};
    mode_d = state_d;

    mask_d = MASK_ALL;
    if (!blink_on_d) begin
      case (state_d)
        ST_SET_HR:  mask_d = 6'b001111;
        ST_SET_MIN: mask_d = 6'b110011;
        ST_SET_SEC: mask_d = 6'b111100;
        default:    mask_d = MASK_ALL;
      endcase
    end

    if (state_d != ST_RUN) begin
      point_d = POINT_LIT;
    end else if (presc_d < PRESC_HALF) begin
      point_d = POINT_LIT;
    end else begin
      point_d = POINT_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      hr_q        <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      din_q       <= 24'h000000;
      mask_q      <= MASK_ALL;
      point_q     <= POINT_OFF;
      mode_q      <= ST_RUN;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      din_q       <= din_d;
      mask_q      <= mask_d;
      point_q     <= point_d;
      mode_q      <= mode_d;
    end
  end

  assign din      = din_q;
  assign din_mask = mask_q;
  assign point_n  = point_q;
  assign mode     = mode_q;

endmodule

// File: tb/tb_clock_disp_ctrl.sv
// tb/tb_clock_disp_ctrl.sv - self-checking bench for clock_disp_ctrl
//
// Ports: none (drives clk, rst_n, key_mode, key_up; observes din, din_mask, point_n, mode)

module tb_clock_disp_ctrl;

  localparam int CF = 10;
  localparam int BH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_mode;
  logic        key_up;
  logic [23:0] din;
  logic [5:0]  din_mask;
  logic [5:0]  point_n;
  logic [1:0]  mode;

  clock_disp_ctrl #(.CLK_FREQ(CF), .BLINK_HALF(BH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_mode (key_mode),
    .key_up   (key_up),
    .din      (din),
    .din_mask (din_mask),
    .point_n  (point_n),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] din;
    logic [5:0]  mask;
    logic [5:0]  point;
    logic [1:0]  mode;
  } exp_t;

  typedef struct {
    logic        km;
    logic        ku;
    int          reps;
    int          gap;
    logic [23:0] din;
    logic [1:0]  mode;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[28];

  int total = 0;
  int bad   = 0;

  // reference model state (plain integers)
  int m_st, m_h, m_m, m_s, m_pr, m_bc;
  bit m_bon;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_pr = 0; m_bc = 0; m_bon = 1'b1;
  endtask

  task automatic model_step(input logic km, input logic ku, output exp_t e);
    int  ns;
    bit  tick;
    bit  upok;
    tick = (m_st == 0) && (m_pr == CF - 1);
    upok = ku && !km && (m_st != 0);
    ns   = km ? (m_st + 1) % 4 : m_st;
    if (tick) begin
      m_s++;
      if (m_s == 60) begin
        m_s = 0;
        m_m++;
        if (m_m == 60) begin
          m_m = 0;
          m_h = (m_h + 1) % 24;
        end
      end
    end
    if (upok) begin
      if (m_st == 1) m_h = (m_h + 1) % 24;
      else if (m_st == 2) m_m = (m_m + 1) % 60;
      else m_s = (m_s + 1) % 60;
    end
    m_pr = (m_st == 0 && ns == 0) ? (m_pr + 1) % CF : 0;
    if ((km && ns != 0) || upok) begin
      m_bc = 0; m_bon = 1'b1;
    end else if (m_bc == BH - 1) begin
      m_bc = 0; m_bon = !m_bon;
    end else begin
      m_bc++;
    end
    m_st = ns;
    e.din  = {bcd(m_h), bcd(m_m), bcd(m_s)};
    e.mode = 2'(m_st);
    if (m_st == 0 || m_bon) e.mask = 6'h3F;
    else if (m_st == 1) e.mask = 6'b001111;
    else if (m_st == 2) e.mask = 6'b110011;
    else e.mask = 6'b111100;
    e.point = (m_st != 0 || m_pr < CF / 2) ? 6'b101011 : 6'b111111;
  endtask

  task automatic step(input logic km, input logic ku);
    exp_t e;
    exp_t g;
    key_mode = km;
    key_up   = ku;
    model_step(km, ku, e);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = sb_q.pop_front();
    check("sb_din",   32'(din),      32'(g.din));
    check("sb_mask",  32'(din_mask), 32'(g.mask));
    check("sb_point", 32'(point_n),  32'(g.point));
    check("sb_mode",  32'(mode),     32'(g.mode));
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        step(vecs[i].km, vecs[i].ku);
        for (int g = 0; g < vecs[i].gap; g++) step(1'b0, 1'b0);
      end
      check($sformatf("vec%0d_din", i),  32'(din),  32'(vecs[i].din));
      check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].mode));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_din"},   32'(din),      32'h000000);
    check({tag, "_mask"},  32'(din_mask), 32'h3F);
    check({tag, "_point"}, 32'(point_n),  32'h3F);
    check({tag, "_mode"},  32'(mode),     32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            km    ku    reps gap din          mode
    vecs[0]  = '{1'b0, 1'b0, 10,  0, 24'h000001, 2'd0};
    vecs[1]  = '{1'b0, 1'b1, 1,   0, 24'h000001, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, 3,   0, 24'h000001, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 1,   0, 24'h000001, 2'd1};
    vecs[4]  = '{1'b0, 1'b1, 25,  1, 24'h010001, 2'd1};
    vecs[5]  = '{1'b1, 1'b0, 1,   0, 24'h010001, 2'd2};
    vecs[6]  = '{1'b0, 1'b1, 59,  0, 24'h015901, 2'd2};
    vecs[7]  = '{1'b0, 1'b1, 1,   0, 24'h010001, 2'd2};
    vecs[8]  = '{1'b1, 1'b1, 1,   0, 24'h010001, 2'd3};
    vecs[9]  = '{1'b0, 1'b0, 100, 0, 24'h010001, 2'd3};
    vecs[10] = '{1'b1, 1'b0, 1,   9, 24'h010001, 2'd0};
    vecs[11] = '{1'b0, 1'b0, 1,   0, 24'h010002, 2'd0};
    vecs[12] = '{1'b1, 1'b0, 1,   0, 24'h010002, 2'd1};
    vecs[13] = '{1'b0, 1'b1, 22,  0, 24'h230002, 2'd1};
    vecs[14] = '{1'b1, 1'b0, 1,   0, 24'h230002, 2'd2};
    vecs[15] = '{1'b0, 1'b1, 59,  0, 24'h235902, 2'd2};
    vecs[16] = '{1'b1, 1'b0, 1,   0, 24'h235902, 2'd3};
    vecs[17] = '{1'b0, 1'b1, 57,  0, 24'h235959, 2'd3};
    vecs[18] = '{1'b1, 1'b0, 1,   9, 24'h235959, 2'd0};
    vecs[19] = '{1'b0, 1'b0, 1,   0, 24'h000000, 2'd0};
    vecs[20] = '{1'b1, 1'b0, 1,   0, 24'h000000, 2'd1};
    vecs[21] = '{1'b0, 1'b1, 12,  0, 24'h120000, 2'd1};
    vecs[22] = '{1'b1, 1'b0, 1,   0, 24'h120000, 2'd2};
    vecs[23] = '{1'b0, 1'b1, 34,  0, 24'h123400, 2'd2};
    vecs[24] = '{1'b1, 1'b0, 1,   0, 24'h123400, 2'd3};
    vecs[25] = '{1'b0, 1'b1, 56,  0, 24'h123456, 2'd3};
    vecs[26] = '{1'b1, 1'b0, 2,   0, 24'h123456, 2'd1};
    vecs[27] = '{1'b0, 1'b0, 10,  0, 24'h000001, 2'd0};

    rst_n    = 1'b0;
    key_mode = 1'b0;
    key_up   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    run_vecs(0, 3);

    // blink phase after entering SET_HR: shown 4 cycles, hidden 4, shown again
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("blink_%0d", i), 32'(din_mask),
            32'((i >= 4 && i < 8) ? 6'h0F : 6'h3F));
    end

    run_vecs(4, 26);

    // asynchronous reset in SET_HR showing 12:34:56, checked before the next edge
    key_mode = 1'b0;
    key_up   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    check_reset_outputs("hold");
    rst_n = 1'b1;

    run_vecs(27, 27);

    check("sb_left", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_disp_ctrl.md
CLOCK_DISP_CTRL -- requirements
Module: clock_disp_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, clk cycles per 1 s tick.
REQ-002 SHALL have parameter BLINK_HALF, default 12_500_000, clk cycles per blink half-period (250 ms).
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 key_mode  input  1  one-cycle pulse, debounced upstream; advances edit mode.
REQ-006 key_up  input  1  one-cycle pulse, debounced upstream; increments the selected field.
REQ-007 din  output  24  BCD digits to the segment driver: [23:16] hours, [15:8] minutes, [7:0] seconds; digit i = din[4i+3:4i].
REQ-008 din_mask  output  6  digit enable, bit i enables digit i, high = shown.
REQ-009 point_n  output  6  decimal points, bit i for digit i, low = lit.
REQ-010 mode  output  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.

Function
REQ-011 SHALL hold time as BCD: hours 00-23, minutes 00-59, seconds 00-59; no invalid BCD code ever stored.
REQ-012 State machine: key_mode moves RUN->SET_HR->SET_MIN->SET_SEC->RUN; with no key_mode the state holds.
REQ-013 Prescaler counts 0..CLK_FREQ-1 only in RUN; a tick is issued in the cycle it equals CLK_FREQ-1, then it wraps to 0.
REQ-014 In RUN, each tick increments seconds with carry: 59 s -> 00 and +1 min; 59 min -> 00 and +1 h; 23:59:59 -> 00:00:00.
REQ-015 In any SET state the prescaler is held at 0 and no tick occurs; the first tick after returning to RUN comes exactly CLK_FREQ cycles after the return.
REQ-016 In SET_HR/SET_MIN/SET_SEC, key_up increments only the selected field: hours mod 24, minutes and seconds mod 60; no carry into other fields.
REQ-017 key_up in RUN SHALL be ignored.
REQ-018 If key_mode and key_up assert in the same cycle, key_mode SHALL take effect and key_up SHALL be ignored.
REQ-019 Blink counter runs 0..BLINK_HALF-1 and toggles blink_on at the wrap; on entry to any SET state and on every accepted key_up it SHALL reset to 0 with blink_on=1.
REQ-020 din_mask: 6'b111111 in RUN and whenever blink_on=1; when blink_on=0, SET_HR clears bits 5:4, SET_MIN clears bits 3:2, SET_SEC clears bits 1:0.
REQ-021 point_n: bits 4 and 2 lit (6'b101011) in all SET states; in RUN lit while prescaler < CLK_FREQ/2, else 6'b111111.
REQ-022 din, din_mask, point_n and mode are registered and SHALL reflect the internal time/state with exactly 1 clk latency.
REQ-023 A time update from a tick or key_up SHALL appear on din one cycle after the event cycle.

Reset
REQ-024 While rst_n=0, all of the following SHALL hold: time 00:00:00, state RUN, prescaler 0, blink counter 0, blink_on=1.
REQ-025 Reset values: din=24'h000000, din_mask=6'h3F, point_n=6'h3F, mode=0.
REQ-026 Reset asserted mid-edit or mid-count SHALL return the block to the REQ-024 state immediately, without waiting for a clock edge; counting resumes from 0 after release.

Verification (CLK_FREQ=10, BLINK_HALF=4)
REQ-027 Release reset and run 10 cycles -> din goes 24'h000000 to 24'h000001 one cycle after the first tick; point_n alternates 6'b101011 / 6'b111111 every 5 cycles.
REQ-028 Preload 23:59:59 via the SET modes, return to RUN, wait 10 cycles -> din=24'h000000.
REQ-029 key_mode once, then key_up x25 -> mode=1, din[23:16]=8'h01, minutes and seconds unchanged; din_mask toggles bits 5:4 every 4 cycles and reads 6'h3F right after each key_up.
REQ-030 In SET_MIN with minutes=59, key_up -> minutes=00 and hours unchanged; key_mode and key_up in the same cycle -> mode=3, minutes unchanged.
REQ-031 In RUN, key_up pulses -> din unchanged. In SET_SEC, wait 100 cycles -> din unchanged. key_mode to RUN -> next increment appears exactly 11 cycles later.
REQ-032 Assert rst_n low asynchronously while in SET_HR with din=24'h123456 -> outputs take REQ-025 values before the next clk edge.
